seq_chunk_adder: RTL and testbench
==================================

// Module: seq_chunk_adder
// PURPOSE
//  Multi-cycle WIDTH-bit add/subtract unit that processes CHUNK bits per cycle,
//  carrying between slices in a register (ripple-carry in time, not in space).
//  Adds valid/ready handshakes, subtract mode, signed-overflow flag, and an
//  internal accumulator. Serves as the low-area accumulate datapath for the
//  digit-detection neuron sums.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK   4   bits added per cycle; NCHUNK = WIDTH/CHUNK cycles per operation
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  in_valid  in   1      operand set valid
//  in_ready  out  1      block can accept operands (high only in IDLE)
//  a         in   WIDTH  operand A (ignored when acc_en=1)
//  b         in   WIDTH  operand B
//  c_in      in   1      carry-in (ignored when sub=1)
//  sub       in   1      1: result = A - B (B inverted, carry-in forced 1)
//  acc_en    in   1      1: operand A is the internal accumulator value
//  acc_clr   in   1      clears accumulator to 0 (only honoured in IDLE)
//  out_valid out  1      result valid
//  out_ready in   1      consumer accepts result
//  sum       out  WIDTH  result
//  c_out     out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf       out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0,
//    accumulator=0, chunk index=0. Reset in any state aborts the operation;
//    partial results are discarded, no out_valid is produced.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready at an edge: latch A (or acc),
//    B (or ~B if sub), carry=(sub ? 1 : c_in), mode bits; index=0; go RUN.
//    acc_clr in IDLE zeroes acc at that edge; acc_clr with accept in the same
//    cycle: clear first, so acc_en uses A=0.
//  - RUN: each edge adds slice [index*CHUNK +: CHUNK] of A, B plus carry
//    register; writes slice of sum; updates carry; index++. After NCHUNK edges
//    -> DONE. On the final slice, record carry into MSB for ovf.
//  - Latency: out_valid rises exactly NCHUNK cycles after the accepting edge.
//    Throughput: one operation per NCHUNK+2 cycles with out_ready held high.
//  - DONE: out_valid=1; sum, c_out, ovf stable until out_valid&out_ready edge,
//    then -> IDLE, out_valid=0. If acc_en was set for this op, accumulator
//    loads sum at that edge (accumulator updates only on result handshake).
//  - in_ready=0 in RUN and DONE; in_valid ignored there. out_ready ignored
//    outside DONE. acc_clr ignored outside IDLE.
//  - Arithmetic is modulo 2^WIDTH; sum outputs hold last result in IDLE.
//  - WIDTH == CHUNK is legal (NCHUNK=1, single RUN cycle).
// TESTING
//  1 WIDTH16/CHUNK4: a=0xFFFF,b=0x0001,c_in=0 -> sum=0x0000,c_out=1,ovf=0,
//    out_valid exactly 4 cycles after accept.
//  2 sub=1, a=0x8000,b=0x0001 -> sum=0x7FFF,c_out=1,ovf=1; a=0x0003,b=0x0005
//    -> sum=0xFFFE,c_out=0,ovf=0.
//  3 acc_clr, then three ops acc_en=1,b=0x0005 -> sums 5,10,15; acc=0x000F;
//    sub with acc_en,b=0x0010 -> sum=0xFFFF.
//  4 out_ready low 3 cycles in DONE -> sum/out_valid held, in_ready=0, a new
//    in_valid not accepted; accepted on first cycle back in IDLE.
//  5 rst asserted on 2nd RUN cycle -> next cycle IDLE, out_valid never
//    pulses, acc=0; next op 0x1234+0x1111 -> 0x2345.
//  6 WIDTH8/CHUNK8: 0x7F+0x01 -> sum=0x80,ovf=1,c_out=0, latency 1 cycle.

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Chunk-serial add/subtract unit: CHUNK bits per cycle with the carry held in a register,
// plus an internal accumulator that can stand in for operand A. WIDTH must be a multiple of CHUNK.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_chunk_adder_if.slave bus,
  output logic [1:0]       dbg_state,
  output logic [WIDTH-1:0] dbg_acc
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             acc_en_q, acc_en_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   slice_sum;
  logic             msb_cin;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] acc_src;

  // Operands shift right one slice per RUN cycle, so the active slice is always the low CHUNK bits.
  always_comb begin
    a_slice   = op_a_q[CHUNK-1:0];
    b_slice   = op_b_q[CHUNK-1:0];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from its sum bit and operand bits.
    msb_cin   = slice_sum[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1];
    res_shift = (res_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    sum_d    = sum_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    acc_en_d = acc_en_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    acc_src  = bus.acc_clr ? '0 : acc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.acc_clr) begin
          acc_d = '0;
        end
        // A clear in the accepting cycle takes effect before acc is captured as operand A.
        if (bus.in_valid) begin
          op_a_d   = bus.acc_en ? acc_src : bus.a;
          op_b_d   = bus.sub ? ~bus.b : bus.b;
          carry_d  = bus.sub ? 1'b1 : bus.c_in;
          acc_en_d = bus.acc_en;
          res_d    = '0;
          idx_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        op_a_d  = op_a_q >> CHUNK;
        op_b_d  = op_b_q >> CHUNK;
        carry_d = slice_sum[CHUNK];
        res_d   = res_shift;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = res_shift;
          c_out_d = slice_sum[CHUNK];
          ovf_d   = msb_cin ^ slice_sum[CHUNK];
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          if (acc_en_q) begin
            acc_d = sum_q;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      sum_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      acc_en_q <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q    <= res_d;
      sum_q    <= sum_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      acc_en_q <= acc_en_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;
  assign dbg_acc       = acc_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: a 16/4 instance and an 8/8 instance, results checked
// by per-instance monitors against expected queues filled when operands are issued.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) bus16 ();
  seq_chunk_adder_if #(.WIDTH(8))  bus8 ();

  logic [1:0]  dbg_state16, dbg_state8;
  logic [15:0] dbg_acc16;
  logic [7:0]  dbg_acc8;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .bus(bus16), .dbg_state(dbg_state16), .dbg_acc(dbg_acc16)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .dbg_state(dbg_state8), .dbg_acc(dbg_acc8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];   // {sum, c_out, ovf}
  logic [9:0]  exp8_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && bus16.out_valid && bus16.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL result16_unexpected: got sum 0x%0h, expected no result", bus16.sum);
      end else begin
        check("result16", 32'({bus16.sum, bus16.c_out, bus16.ovf}), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus8.out_valid && bus8.out_ready) begin
      if (exp8_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL result8_unexpected: got sum 0x%0h, expected no result", bus8.sum);
      end else begin
        check("result8", 32'({bus8.sum, bus8.c_out, bus8.ovf}), 32'(exp8_q.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c_in,
                         input logic sub, input logic acc_en, input logic acc_clr,
                         input logic [17:0] exp, input bit push);
    int n = 0;
    @(posedge clk); #1;
    bus16.a = a; bus16.b = b; bus16.c_in = c_in; bus16.sub = sub;
    bus16.acc_en = acc_en; bus16.acc_clr = acc_clr; bus16.in_valid = 1'b1;
    while (!bus16.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus16.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept16_timeout: in_ready low for %0d cycles, expected high", n);
    end
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    bus16.acc_clr  = 1'b0;
  endtask

  task automatic wait_out16(input int lat);
    int n = 0;
    while (!bus16.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("latency16", n, lat);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c_in,
                      input logic sub, input logic acc_en, input logic acc_clr,
                      input logic [17:0] exp);
    issue16(a, b, c_in, sub, acc_en, acc_clr, exp, 1'b1);
    wait_out16(4);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c_in,
                     input logic sub, input logic [9:0] exp);
    int n = 0;
    @(posedge clk); #1;
    bus8.a = a; bus8.b = b; bus8.c_in = c_in; bus8.sub = sub; bus8.in_valid = 1'b1;
    while (!bus8.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("accept8_ready", 32'(bus8.in_ready), 32'd1);
    exp8_q.push_back(exp);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    n = 0;
    while (!bus8.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("latency8", n, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.c_in = 1'b0; bus16.sub = 1'b0;
    bus16.acc_en = 1'b0; bus16.acc_clr = 1'b0; bus16.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0; bus8.sub = 1'b0;
    bus8.acc_en = 1'b0; bus8.acc_clr = 1'b0; bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_in_ready", 32'(bus16.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    check("rst_sum", 32'(bus16.sum), 32'd0);
    check("rst_c_out", 32'(bus16.c_out), 32'd0);
    check("rst_ovf", 32'(bus16.ovf), 32'd0);
    check("rst_acc", 32'(dbg_acc16), 32'd0);
    check("rst_state", 32'(dbg_state16), 32'd0);
    check("rst8_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst8_out_valid", 32'(bus8.out_valid), 32'd0);

    // plain adds
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
    op16(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0});
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});

    // subtract (c_in ignored in the second)
    op16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, {16'h7FFF, 1'b1, 1'b1});
    op16(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0, {16'hFFFE, 1'b0, 1'b0});

    // accumulator: load, clear, accumulate, subtract from acc
    op16(16'hFFFF, 16'h0042, 1'b0, 1'b0, 1'b1, 1'b0, {16'h0042, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("acc_load", 32'(dbg_acc16), 32'h0042);
    bus16.acc_clr = 1'b1;
    @(posedge clk); #1;
    bus16.acc_clr = 1'b0;
    check("acc_clr", 32'(dbg_acc16), 32'h0000);
    op16(16'hAAAA, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, {16'h0005, 1'b0, 1'b0});
    op16(16'hAAAA, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, {16'h000A, 1'b0, 1'b0});
    op16(16'hAAAA, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, {16'h000F, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("acc_after_three", 32'(dbg_acc16), 32'h000F);
    op16(16'h0000, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, {16'hFFFF, 1'b0, 1'b0});
    // clear and accept together: acc operand is zero
    op16(16'h1234, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b1, {16'h0007, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("acc_clr_with_accept", 32'(dbg_acc16), 32'h0007);

    // backpressure in DONE
    bus16.out_ready = 1'b0;
    issue16(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0, {16'h0300, 1'b0, 1'b0}, 1'b1);
    wait_out16(4);
    bus16.a = 16'h0001; bus16.b = 16'h0001; bus16.c_in = 1'b0; bus16.sub = 1'b0;
    bus16.acc_en = 1'b0; bus16.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(bus16.out_valid), 32'd1);
      check("hold_sum", 32'(bus16.sum), 32'h0300);
      check("hold_in_ready", 32'(bus16.in_ready), 32'd0);
    end
    exp_q.push_back({16'h0002, 1'b0, 1'b0});
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_handshake", 32'(dbg_state16), 32'd0);
    check("ready_after_handshake", 32'(bus16.in_ready), 32'd1);
    @(posedge clk); #1;
    check("accept_first_idle", 32'(dbg_state16), 32'd1);
    bus16.in_valid = 1'b0;
    wait_out16(4);

    // reset during the second RUN cycle
    issue16(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_state", 32'(dbg_state16), 32'd0);
    check("abort_in_ready", 32'(bus16.in_ready), 32'd1);
    check("abort_acc", 32'(dbg_acc16), 32'd0);
    check("abort_sum", 32'(bus16.sum), 32'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus16.out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    op16(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, {16'h2345, 1'b0, 1'b0});

    // single-slice instance
    op8(8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1});
    op8(8'h00, 8'h01, 1'b0, 1'b1, {8'hFF, 1'b0, 1'b0});
    op8(8'hFF, 8'h01, 1'b1, 1'b0, {8'h01, 1'b1, 1'b0});

    repeat (5) @(posedge clk);
    #1;
    check("queue16_drained", exp_q.size(), 0);
    check("queue8_drained", exp8_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
